// File: rtl/boid_fb_pkg.sv
// Shared geometry, coordinate widths, sweep state encoding and the pixel address helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package boid_fb_pkg;

    localparam int WIDTH               = 640;
    localparam int HEIGHT              = 480;
    localparam int PIXEL_ADDRESS_WIDTH = 20;
    localparam int X_W                 = 10;
    localparam int Y_W                 = 9;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        FETCH,
        LATCH,
        DRAW,
        DONE
    } fb_state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } boid_pos_t;

    // x + 640*y built from two shifts; operands widened to 20 bits, result wraps at 20 bits
    function automatic logic [PIXEL_ADDRESS_WIDTH-1:0] pixel_addr(
        input logic [X_W:0] xx,
        input logic [Y_W:0] yy
    );
        logic [PIXEL_ADDRESS_WIDTH-1:0] y_ext;
        logic [PIXEL_ADDRESS_WIDTH-1:0] x_ext;
        y_ext = {{(PIXEL_ADDRESS_WIDTH-Y_W-1){1'b0}}, yy};
        x_ext = {{(PIXEL_ADDRESS_WIDTH-X_W-1){1'b0}}, xx};
        return (y_ext << 9) + (y_ext << 7) + x_ext;
    endfunction

endpackage

// File: rtl/boid_fb_if.sv
// Position-fetch and frame-memory write bus between the sprite writer and its neighbours.
// Latency: pos_x/pos_y are expected one cycle after pos_idx changes.
// Backpressure: none; frame memory accepts one write per cycle.
interface boid_fb_if
    import boid_fb_pkg::*;
#(
    parameter int IDX_W = 4
);
    logic [IDX_W-1:0]               pos_idx;
    logic [X_W-1:0]                 pos_x;
    logic [Y_W-1:0]                 pos_y;
    logic                           fb_wr_en;
    logic [PIXEL_ADDRESS_WIDTH-1:0] fb_wr_addr;
    logic                           fb_wr_data;

    modport master (
        output pos_idx, fb_wr_en, fb_wr_addr, fb_wr_data,
        input  pos_x, pos_y
    );

    modport slave (
        input  pos_idx, fb_wr_en, fb_wr_addr, fb_wr_data,
        output pos_x, pos_y
    );
endinterface

// File: rtl/boid_pos_history.sv
// Last drawn position and valid flag per boid, so the next sweep knows what to erase.
// Latency: write lands on the next clock edge; read is combinational.
// Backpressure: none; one write per cycle always accepted.
module boid_pos_history
    import boid_fb_pkg::*;
#(
    parameter  int NUM_BOIDS = 16,
    localparam int IDX_W     = $clog2(NUM_BOIDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  boid_pos_t        wr_pos,
    input  logic [IDX_W-1:0] rd_idx,
    output boid_pos_t        rd_pos,
    output logic             rd_vld
);
    boid_pos_t            pos_mem [NUM_BOIDS];
    logic [NUM_BOIDS-1:0] vld_q;

    // position storage needs no reset: the valid bit guards every use
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pos_mem[wr_idx] <= wr_pos;
        end
    end

    // valid bits: cleared by reset, set when a boid's position is latched
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else if (wr_en) begin
            vld_q[wr_idx] <= 1'b1;
        end
    end

    assign rd_pos = pos_mem[rd_idx];
    assign rd_vld = vld_q[rd_idx];
endmodule

// File: rtl/boid_fb_writer.sv
// Per screen end: erase every boid's old SxS sprite, then fetch and draw each new one. Clipping under BOID_FB_CLIP_EN.
// Latency: sweep starts the cycle after a frame_start rising edge; N*S*S + N*(2+S*S) + 1 cycles long.
// Backpressure: none; an edge arriving mid-sweep is dropped and flagged on overrun.
module boid_fb_writer #(
    parameter int NUM_BOIDS = 16,
    parameter int BOID_SIZE = 2,
    parameter int WIDTH     = boid_fb_pkg::WIDTH,
    parameter int HEIGHT    = boid_fb_pkg::HEIGHT
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     frame_start,
    boid_fb_if.master fb,
    output logic     busy,
    output logic     frame_done,
    output logic     overrun
);
    import boid_fb_pkg::*;

    localparam int         IDX_W  = $clog2(NUM_BOIDS);
    localparam logic [1:0] S_LAST = 2'(BOID_SIZE - 1);

    if (NUM_BOIDS < 2 || (NUM_BOIDS & (NUM_BOIDS - 1)) != 0) begin : g_bad_num_boids
        $error("NUM_BOIDS must be a power of two >= 2");
    end
    if (BOID_SIZE < 1 || BOID_SIZE > 4) begin : g_bad_boid_size
        $error("BOID_SIZE must be 1..4");
    end
    if (WIDTH > 1024 || HEIGHT > 512) begin : g_bad_geometry
        $error("WIDTH/HEIGHT exceed coordinate widths");
    end

    fb_state_t        state_q, state_d;
    logic [IDX_W-1:0] boid_q;
    logic [1:0]       dx_q, dy_q;
    logic             fs_q, fs_q2;
    logic             fs_rise;
    logic             last_px, last_boid;
    boid_pos_t        rd_pos;
    logic             rd_vld;
    logic [X_W:0]     xx;
    logic [Y_W:0]     yy;
    logic             in_frame;

    // frame_start synchroniser stage plus previous sample for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_q  <= 1'b0;
            fs_q2 <= 1'b0;
        end else begin
            fs_q  <= frame_start;
            fs_q2 <= fs_q;
        end
    end

    assign fs_rise   = fs_q & ~fs_q2;
    assign last_px   = (dx_q == S_LAST) && (dy_q == S_LAST);
    assign last_boid = (boid_q == IDX_W'(NUM_BOIDS - 1));

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state sequencing through erase, then fetch/latch/draw per boid
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fs_rise) state_d = ERASE;
            ERASE:   if (last_px && last_boid) state_d = FETCH;
            FETCH:   state_d = LATCH;
            LATCH:   state_d = DRAW;
            DRAW:    if (last_px) state_d = last_boid ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // pixel walk: dx fastest, then dy, then boid; boid wraps to 0 after the last one
    always_ff @(posedge clk) begin
        if (reset) begin
            boid_q <= '0;
            dx_q   <= '0;
            dy_q   <= '0;
        end else if (state_q == ERASE || state_q == DRAW) begin
            if (dx_q == S_LAST) begin
                dx_q <= '0;
                if (dy_q == S_LAST) begin
                    dy_q   <= '0;
                    boid_q <= boid_q + IDX_W'(1);
                end else begin
                    dy_q <= dy_q + 2'd1;
                end
            end else begin
                dx_q <= dx_q + 2'd1;
            end
        end
    end

    boid_pos_history #(
        .NUM_BOIDS (NUM_BOIDS)
    ) u_hist (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (state_q == LATCH),
        .wr_idx (boid_q),
        .wr_pos ({fb.pos_x, fb.pos_y}),
        .rd_idx (boid_q),
        .rd_pos (rd_pos),
        .rd_vld (rd_vld)
    );

    assign xx = {1'b0, rd_pos.x} + {{(X_W-1){1'b0}}, dx_q};
    assign yy = {1'b0, rd_pos.y} + {{(Y_W-1){1'b0}}, dy_q};

`ifdef BOID_FB_CLIP_EN
    localparam logic [X_W:0] X_LIM = (X_W+1)'(WIDTH);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(HEIGHT);
    assign in_frame = (xx < X_LIM) && (yy < Y_LIM);
`else
    assign in_frame = 1'b1;
`endif

    // outputs decoded from the registered state and walk counters
    always_comb begin
        fb.fb_wr_en   = 1'b0;
        fb.fb_wr_addr = '0;
        fb.fb_wr_data = 1'b0;
        fb.pos_idx    = boid_q;
        busy          = (state_q != IDLE);
        frame_done    = (state_q == DONE);
        overrun       = fs_rise && (state_q != IDLE);
        case (state_q)
            ERASE: begin
                fb.fb_wr_en   = rd_vld && in_frame;
                fb.fb_wr_addr = pixel_addr(xx, yy);
            end
            DRAW: begin
                fb.fb_wr_en   = in_frame;
                fb.fb_wr_addr = pixel_addr(xx, yy);
                fb.fb_wr_data = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_boid_fb_writer.sv
// Randomised sweeps checked cycle by cycle against a per-sweep write schedule built from sprite geometry.
// Latency: each sweep observed from the edge cycle to one cycle past frame_done.
// Backpressure: n/a; position source answers one cycle after pos_idx.
module tb_boid_fb_writer;
    localparam int N = 16;
    localparam int S = 2;
    localparam int L = N*S*S + N*(2+S*S) + 1;

    logic clk = 1'b0;
    logic reset;
    logic frame_start;
    logic busy, frame_done, overrun;

    boid_fb_if #(.IDX_W(4)) fb_bus();

    boid_fb_writer #(
        .NUM_BOIDS (N),
        .BOID_SIZE (S),
        .WIDTH     (640),
        .HEIGHT    (480)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .fb          (fb_bus),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] px_tab [N];
    logic [8:0] py_tab [N];
    int         hx [N];
    int         hy [N];
    int         hv [N];
    int         e_en [L];
    int         e_addr [L];
    int         e_dat [L];
    int         e_idx [L];

    // position source: registered lookup, one cycle behind pos_idx
    always @(posedge clk) begin
        fb_bus.pos_x <= px_tab[fb_bus.pos_idx];
        fb_bus.pos_y <= py_tab[fb_bus.pos_idx];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic put(input int slot, input int x, input int y, input int en, input int dat, input int idx);
        int en_c;
        en_c = en;
`ifdef BOID_FB_CLIP_EN
        if (x >= 640 || y >= 480) en_c = 0;
`endif
        e_en[slot]   = en_c;
        e_addr[slot] = (x + 640*y) % (1 << 20);
        e_dat[slot]  = dat;
        e_idx[slot]  = idx;
    endtask

    task automatic build_expected();
        int s;
        s = 0;
        for (int b = 0; b < N; b++)
            for (int dy = 0; dy < S; dy++)
                for (int dx = 0; dx < S; dx++) begin
                    put(s, hx[b] + dx, hy[b] + dy, hv[b], 0, -1);
                    s++;
                end
        for (int b = 0; b < N; b++) begin
            put(s, 0, 0, 0, 0, b); s++;
            put(s, 0, 0, 0, 0, b); s++;
            for (int dy = 0; dy < S; dy++)
                for (int dx = 0; dx < S; dx++) begin
                    put(s, int'(px_tab[b]) + dx, int'(py_tab[b]) + dy, 1, 1, b);
                    s++;
                end
        end
        put(s, 0, 0, 0, 0, -1);
    endtask

    task automatic set_positions(input int mode);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       begin px_tab[i] = 10'(10*i);     py_tab[i] = 9'd5; end
                1:       begin px_tab[i] = 10'(10*i + 1); py_tab[i] = 9'd5; end
                default: begin
                    px_tab[i] = 10'($urandom_range(0, 640 - S));
                    py_tab[i] = 9'($urandom_range(0, 480 - S));
                end
            endcase
        end
    endtask

    // one sweep: edge held for 'hold' cycles, optional extra edge raised at cycle ovr_at
    task automatic run_sweep(input int hold, input int ovr_at);
        int ovr_seen;
        int j;
        build_expected();
        ovr_seen = 0;
        @(negedge clk);
        frame_start = 1'b1;
        for (int k = 0; k <= L + 1; k++) begin
            @(negedge clk);
            j = k - 1;
            if (k == 0 || k == L + 1) begin
                chk($sformatf("busy_idle[%0d]", k), int'(busy), 0);
                chk($sformatf("wr_en_idle[%0d]", k), int'(fb_bus.fb_wr_en), 0);
            end else begin
                chk($sformatf("busy[%0d]", j), int'(busy), 1);
                chk($sformatf("frame_done[%0d]", j), int'(frame_done), (j == L - 1) ? 1 : 0);
                chk($sformatf("wr_en[%0d]", j), int'(fb_bus.fb_wr_en), e_en[j]);
                if (e_en[j] != 0) begin
                    chk($sformatf("wr_addr[%0d]", j), int'(fb_bus.fb_wr_addr), e_addr[j]);
                    chk($sformatf("wr_data[%0d]", j), int'(fb_bus.fb_wr_data), e_dat[j]);
                end
                if (e_idx[j] >= 0)
                    chk($sformatf("pos_idx[%0d]", j), int'(fb_bus.pos_idx), e_idx[j]);
            end
            if (overrun) ovr_seen++;
            if (k == hold - 1) frame_start = 1'b0;
            if (ovr_at > 0 && k == ovr_at) frame_start = 1'b1;
            if (ovr_at > 0 && k == ovr_at + 2) frame_start = 1'b0;
        end
        chk("overrun_pulses", ovr_seen, (ovr_at > 0) ? 1 : 0);
        for (int b = 0; b < N; b++) begin
            hx[b] = int'(px_tab[b]);
            hy[b] = int'(py_tab[b]);
            hv[b] = 1;
        end
        repeat (3) @(negedge clk);
    endtask

    // reset lands inside boid 5's draw phase
    task automatic reset_mid_draw();
        @(negedge clk);
        frame_start = 1'b1;
        for (int k = 0; k <= 100; k++) begin
            @(negedge clk);
            if (k == 0) frame_start = 1'b0;
        end
        chk("pre_reset_wr_en", int'(fb_bus.fb_wr_en), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_wr_en", int'(fb_bus.fb_wr_en), 0);
        chk("reset_busy", int'(busy), 0);
        reset = 1'b0;
        for (int b = 0; b < N; b++) hv[b] = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        set_positions(0);
        for (int b = 0; b < N; b++) begin
            hx[b] = 0;
            hy[b] = 0;
            hv[b] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_wr_en", int'(fb_bus.fb_wr_en), 0);
        chk("rst_wr_addr", int'(fb_bus.fb_wr_addr), 0);
        chk("rst_wr_data", int'(fb_bus.fb_wr_data), 0);
        chk("rst_pos_idx", int'(fb_bus.pos_idx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_overrun", int'(overrun), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_sweep(1, 0);
        set_positions(1);
        run_sweep(4, 0);
        set_positions(2);
        run_sweep(1, 50);
        set_positions(2);
        px_tab[0] = 10'd639;
        py_tab[0] = 9'd479;
        run_sweep(1, 0);
        set_positions(2);
        run_sweep(2, 0);
        reset_mid_draw();
        set_positions(2);
        run_sweep(1, 0);
        set_positions(2);
        run_sweep(3, 90);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/boid_fb_writer.md
# boid_fb_writer

Writes boid sprites into the 1-bit boid frame memory that the VGA display path reads (address = x + 640*y, 1 = boid pixel). On each screen-end event it erases every boid at its previously drawn position. It then fetches each boid's new position and draws an S×S square there. It is the write port counterpart of the display read path, clocked on the 100 MHz system clock.

## Interface
Parameters:
- NUM_BOIDS, 16, number of boids, power of two ≥ 2
- BOID_SIZE, 2, sprite edge S in pixels, 1..4
- WIDTH, 640, visible width
- HEIGHT, 480, visible height

Ports:
- clk  in  1  100 MHz system clock; one clock, all logic on posedge
- reset  in  1  synchronous, active-high
- frame_start  in  1  screen-end signal from the VGA timing generator; level, high for several clk cycles (one clk25 period)
- pos_idx  out  log2(NUM_BOIDS)  boid index being fetched
- pos_x  in  10  x of boid pos_idx; valid one cycle after pos_idx changes
- pos_y  in  9  y of boid pos_idx; same timing as pos_x
- fb_wr_en  out  1  frame memory write strobe
- fb_wr_addr  out  20  frame memory write address
- fb_wr_data  out  1  1 = draw, 0 = erase
- busy  out  1  sweep in progress
- frame_done  out  1  one-cycle pulse when a sweep completes
- overrun  out  1  one-cycle pulse when a frame_start edge arrives while busy

## Operation
- frame_start is registered; a sweep is triggered by a rising edge (high now, low last cycle), so one trigger occurs per screen end.
- State machine: IDLE → ERASE → FETCH → LATCH → DRAW → (FETCH for the next boid | DONE) → IDLE.
- ERASE: for i = 0..N-1, for dy, dx = 0..S-1 (dx fastest), one pixel per cycle at the history position of boid i, with data 0.
  - If boid i's history valid bit is 0, the cycle is still consumed with fb_wr_en = 0.
- FETCH: drive pos_idx = i.
- LATCH: capture pos_x/pos_y into the history entry for boid i and set its valid bit.
- DRAW: S*S cycles writing data 1 at the latched position, in the same dx/dy order as ERASE.
- DONE: frame_done = 1 for this one cycle, then return to IDLE.
- Address arithmetic: addr = (x+dx) + (y+dy)*640, computed as ((y+dy)<<9) + ((y+dy)<<7) + (x+dx).
  - All terms are zero-extended to 20 bits; the result is truncated to 20 bits.
- A rising edge while busy: overrun pulses for one cycle, the edge is dropped, and the sweep continues unaffected.
- Reset, including mid-sweep: state goes to IDLE and all history valid bits clear.
  - Pixels already drawn in frame memory are not erased after a reset; this is accepted.
- Reset values: fb_wr_en 0, fb_wr_addr 0, fb_wr_data 0, pos_idx 0, busy 0, frame_done 0, overrun 0.

## Timing
- Edge detected at cycle T (frame_start sampled high at T, low at T-1): ERASE begins at T+1, and the first possible write is at T+1.
- Outputs are registered; fb_wr_* are valid in the same cycle as the state they belong to.
- Sweep length L = N*S*S (ERASE) + N*(2+S*S) (FETCH, LATCH, DRAW) + 1 (DONE). With the defaults, L = 64 + 96 + 1 = 161.
- busy is high from T+1 through T+L inclusive. frame_done is high at T+L only.
- pos_idx holds its value from FETCH through DRAW for that boid.

## Configuration
- BOID_FB_CLIP_EN defined: any pixel with x+dx ≥ WIDTH or y+dy ≥ HEIGHT gets fb_wr_en = 0.
  - The cycle is still consumed, so L is unchanged.
- BOID_FB_CLIP_EN undefined: no comparators; every pixel is written at the truncated address.
  - The position source must keep x ≤ WIDTH-S and y ≤ HEIGHT-S.

## Structure
- Package boid_fb_pkg holds:
  - WIDTH, HEIGHT and PIXEL_ADDRESS_WIDTH = 20
  - coordinate widths (10 for x, 9 for y)
  - the state enum (IDLE, ERASE, FETCH, LATCH, DRAW, DONE)
- Sub-module boid_pos_history: NUM_BOIDS × (10+9+1 valid) register file.
  - One synchronous write port, one asynchronous read port.
  - Synchronous clear of the valid bits on reset.

## Test plan
- Reset, defaults, source returns x = 10*i, y = 5, single edge at T → no writes during T+1..T+64; boid 0 draw writes 3200, 3201, 3840, 3841 with data 1; frame_done only at T+161.
- Second edge with x = 10*i+1 → ERASE writes data 0 at 3200, 3201, 3840, 3841 first; DRAW for boid 0 writes 3201, 3202, 3841, 3842.
- frame_start held high 4 cycles → exactly one sweep; overrun stays 0.
- New edge at T+50 → overrun high for one cycle at T+50 or T+51; no restart; single frame_done at T+161.
- Boid 0 at (639, 479), S = 2 → with BOID_FB_CLIP_EN only address 307199 is written; without it, writes go to 307199, 307200, 307839, 307840.
- reset asserted mid-DRAW → next cycle fb_wr_en = 0 and busy = 0; the following sweep's ERASE phase issues no writes.
